// File: rtl/fa_4bit_pkg.sv
// Purpose: shared width constant and nibble type for the 4-bit adder slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fa_4bit_pkg;

  localparam int FA_WIDTH = 4;

  typedef logic [FA_WIDTH-1:0] nibble_t;

endpackage : fa_4bit_pkg

// File: rtl/fa_4bit_full_adder.sv
// Purpose: single-bit full adder cell, one link of the ripple carry chain.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs continuously.
//
// Ports:
//   a, b  - operand bits
//   cin   - carry into this bit
//   s     - sum bit
//   cout  - carry out of this bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;  // propagate term; reused by both sum and carry

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : full_adder

// File: rtl/fa_4bit.sv
// Purpose: 4-bit ripple-carry adder with carry in/out and a registered copy of the result.
// Latency: sum/carry_out combinational; sum_q/carry_out_q (and flags) one clk cycle.
// Backpressure: none; the output register captures on every rising edge.
//
// Ports:
//   in1, in2     - unsigned addends (two's-complement view used for ovf_q)
//   carry_in     - carry into bit 0
//   sum          - combinational sum [3:0]
//   carry_out    - combinational carry out of bit 3
//   clk, rst     - clock and synchronous active-high reset (registered outputs only)
//   sum_q        - sum registered on the rising edge of clk
//   carry_out_q  - carry_out registered on the rising edge of clk
//   ovf_q        - registered signed overflow    (only with FA_4BIT_FLAGS_EN)
//   zero_q       - registered sum == 0 indicator (only with FA_4BIT_FLAGS_EN)
//
// Optional feature macro: FA_4BIT_FLAGS_EN enables the ovf_q/zero_q status flags.
//
// The first five ports are kept in this order so a positional hookup of the
// combinational adder alone remains valid.
module fa_4bit
  import fa_4bit_pkg::*;
(
  input  nibble_t in1,
  input  nibble_t in2,
  input  logic    carry_in,
  output nibble_t sum,
  output logic    carry_out,
  input  logic    clk,
  input  logic    rst,
  output nibble_t sum_q,
  output logic    carry_out_q
`ifdef FA_4BIT_FLAGS_EN
  ,
  output logic    ovf_q,
  output logic    zero_q
`endif
);

  // w_carry[i] is the carry into bit i; w_carry[FA_WIDTH] is the final carry out.
  logic [FA_WIDTH:0] w_carry;

  assign w_carry[0] = carry_in;

  for (genvar g = 0; g < FA_WIDTH; g++) begin : g_cell
    full_adder u_fa (
      .a    (in1[g]),
      .b    (in2[g]),
      .cin  (w_carry[g]),
      .s    (sum[g]),
      .cout (w_carry[g+1])
    );
  end

  assign carry_out = w_carry[FA_WIDTH];

  // Output register: reset wins over capture, no enable.
  nibble_t r_sum_q;
  logic    r_carry_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_q       <= '0;
      r_carry_out_q <= 1'b0;
    end else begin
      r_sum_q       <= sum;
      r_carry_out_q <= carry_out;
    end
  end

  assign sum_q       = r_sum_q;
  assign carry_out_q = r_carry_out_q;

`ifdef FA_4BIT_FLAGS_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  logic w_ovf;
  // Zero looks only at the 4 sum bits, so 8+8 reports zero despite the carry.
  logic w_zero;
  logic r_ovf_q;
  logic r_zero_q;

  assign w_ovf  = w_carry[FA_WIDTH-1] ^ w_carry[FA_WIDTH];
  assign w_zero = (sum == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_q  <= 1'b0;
      r_zero_q <= 1'b0;
    end else begin
      r_ovf_q  <= w_ovf;
      r_zero_q <= w_zero;
    end
  end

  assign ovf_q  = r_ovf_q;
  assign zero_q = r_zero_q;
`endif

endmodule : fa_4bit

// File: tb/tb_fa_4bit.sv
// Purpose: self-checking bench for fa_4bit (vector table, exhaustive sweep, register corner cases).
// Latency: checks combinational outputs #1 after input change, registered outputs #1 after posedge.
// Backpressure: n/a.
module tb_fa_4bit;
  import fa_4bit_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  nibble_t in1;
  nibble_t in2;
  logic    carry_in;
  nibble_t sum;
  logic    carry_out;
  nibble_t sum_q;
  logic    carry_out_q;
`ifdef FA_4BIT_FLAGS_EN
  logic    ovf_q;
  logic    zero_q;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fa_4bit dut (
    .in1         (in1),
    .in2         (in2),
    .carry_in    (carry_in),
    .sum         (sum),
    .carry_out   (carry_out),
    .clk         (clk),
    .rst         (rst),
    .sum_q       (sum_q),
    .carry_out_q (carry_out_q)
`ifdef FA_4BIT_FLAGS_EN
    ,
    .ovf_q       (ovf_q),
    .zero_q      (zero_q)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] exp_sum;
    logic       exp_co;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    in1      = a;
    in2      = b;
    carry_in = c;
  endtask

  vec_t vecs [5];

  initial begin
    logic [4:0] ref5;

    vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
    vecs[1] = '{4'd7,  4'd8,  1'b0, 4'd15, 1'b0};
    vecs[2] = '{4'd13, 4'd15, 1'b0, 4'd12, 1'b1};
    vecs[3] = '{4'd14, 4'd11, 1'b1, 4'd10, 1'b1};
    vecs[4] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};

    // Reset state
    rst = 1'b1;
    drive(4'd3, 4'd4, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_sum_q", {4'b0, sum_q}, 8'd0);
    chk("reset_co_q", {7'b0, carry_out_q}, 8'd0);
`ifdef FA_4BIT_FLAGS_EN
    chk("reset_ovf_q", {7'b0, ovf_q}, 8'd0);
    chk("reset_zero_q", {7'b0, zero_q}, 8'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Spot-check table
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c);
      #1;
      chk($sformatf("vec%0d_sum", i), {4'b0, sum}, {4'b0, vecs[i].exp_sum});
      chk($sformatf("vec%0d_co", i), {7'b0, carry_out}, {7'b0, vecs[i].exp_co});
    end

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          drive(4'(a), 4'(b), 1'(c));
          #1;
          ref5 = 5'(a) + 5'(b) + 5'(c);
          chk($sformatf("sweep_%0d_%0d_%0d", a, b, c), {3'b0, carry_out, sum}, {3'b0, ref5});
        end
      end
    end

    // Carry chain and carry_in toggle within one half period (no edge)
    @(negedge clk);
    drive(4'd15, 4'd0, 1'b1);
    #1;
    chk("chain_sum", {4'b0, sum}, 8'd0);
    chk("chain_co", {7'b0, carry_out}, 8'd1);
    carry_in = 1'b0;
    #1;
    chk("toggle0_sum", {4'b0, sum}, 8'd15);
    chk("toggle0_co", {7'b0, carry_out}, 8'd0);
    carry_in = 1'b1;
    #1;
    chk("toggle1_co", {7'b0, carry_out}, 8'd1);

    // Register latency: preload 0, then 5+12+1 before edge N
    @(negedge clk);
    drive(4'd0, 4'd0, 1'b0);
    @(negedge clk);
    drive(4'd5, 4'd12, 1'b1);
    #1;
    chk("lat_comb_sum", {4'b0, sum}, 8'd2);
    chk("lat_pre_sum_q", {4'b0, sum_q}, 8'd0);
    chk("lat_pre_co_q", {7'b0, carry_out_q}, 8'd0);
    @(posedge clk);
    #1;
    chk("lat_post_sum_q", {4'b0, sum_q}, 8'd2);
    chk("lat_post_co_q", {7'b0, carry_out_q}, 8'd1);

    // Mid-stream reset held for 2 edges
    @(negedge clk);
    rst = 1'b1;
    drive(4'd9, 4'd2, 1'b1);
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d_sum_q", e), {4'b0, sum_q}, 8'd0);
      chk($sformatf("rst%0d_co_q", e), {7'b0, carry_out_q}, 8'd0);
      chk($sformatf("rst%0d_sum", e), {4'b0, sum}, 8'd12);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_sum_q", {4'b0, sum_q}, 8'd12);
    chk("rel_co_q", {7'b0, carry_out_q}, 8'd0);

`ifdef FA_4BIT_FLAGS_EN
    @(negedge clk);
    drive(4'd5, 4'd2, 1'b1);
    @(posedge clk);
    #1;
    chk("f1_ovf", {7'b0, ovf_q}, 8'd1);
    chk("f1_zero", {7'b0, zero_q}, 8'd0);
    @(negedge clk);
    drive(4'd15, 4'd15, 1'b1);
    @(posedge clk);
    #1;
    chk("f2_ovf", {7'b0, ovf_q}, 8'd0);
    @(negedge clk);
    drive(4'd8, 4'd8, 1'b0);
    @(posedge clk);
    #1;
    chk("f3_zero", {7'b0, zero_q}, 8'd1);
    chk("f3_ovf", {7'b0, ovf_q}, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fa_4bit

// File: doc/fa_4bit.md
# fa_4bit

4-bit ripple-carry adder with carry-in and carry-out, used as the basic arithmetic cell for nibble-wide datapaths. The sum and carry outputs are purely combinational. A clocked output register provides a one-cycle-latency copy of the result for pipelined consumers.

## Interface

Parameters:
- None. Width is fixed at 4 by the package constant `FA_WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock; used only by the registered outputs.
- `rst`  input  1  synchronous, active-high reset; clears the registered outputs only.
- `in1`  input  4  addend A, unsigned (two's-complement view used for `ovf_q`).
- `in2`  input  4  addend B.
- `carry_in`  input  1  carry into bit 0.
- `sum`  output  4  combinational sum bits [3:0].
- `carry_out`  output  1  combinational carry out of bit 3.
- `sum_q`  output  4  `sum` registered on the rising edge of `clk`.
- `carry_out_q`  output  1  `carry_out` registered on the rising edge of `clk`.
- `ovf_q`, `zero_q`  output  1 each  registered status flags; present only with `FA_4BIT_FLAGS_EN`.

Declaration order is `in1, in2, carry_in, sum, carry_out, clk, rst, sum_q, carry_out_q` (then the flags). This keeps a five-port positional hookup of the combinational adder valid.

## Operation

- The combinational result `{carry_out, sum}` equals `in1 + in2 + carry_in`, evaluated at 5 bits. There is no truncation beyond bit 4 and no saturation.
- The adder is built as a ripple chain of four 1-bit full adders:
  - bit i: `s = a ^ b ^ c`, `co = (a & b) | (c & (a ^ b))`.
  - `c0 = carry_in`; `carry_out` is `co` of bit 3.
- The internal carry into bit 3 (`c3`) is exposed internally for overflow detection.
- The full input range is legal, including `in1 = in2 = 15` with `carry_in = 1`, which gives `sum = 15`, `carry_out = 1`.
- Register stage:
  - If `rst` is high at a rising edge, `sum_q`, `carry_out_q` and the flags load 0.
  - Otherwise they load the current combinational values.
- `rst` has no effect on `sum` or `carry_out`.
- X or Z on any input propagates to the outputs; the block does not mask it.

## Timing

- Combinational path: `sum` and `carry_out` are valid within the same delta cycle as an input change, with no clock dependence. The worst case is the full ripple, `carry_in` to `carry_out` through 4 cells.
- Registered path: latency is 1 cycle. Inputs present at edge N appear on `sum_q` and `carry_out_q` after edge N.
- Reset values: `sum_q = 0`, `carry_out_q = 0`, `ovf_q = 0`, `zero_q = 0`.
- Reset wins over capture. Reset asserted mid-stream clears the register at that edge; capture resumes at the first edge with `rst` low.
- There is no enable and no handshake; the register captures on every edge.

## Configuration

- Macro: `FA_4BIT_FLAGS_EN`.
- When defined:
  - Ports `ovf_q` and `zero_q` exist.
  - `ovf_q` registers signed overflow, `c3 ^ carry_out`.
  - `zero_q` registers `sum == 4'b0000`. It ignores `carry_out`, so 8+8+0 gives `zero_q = 1`.
  - Both flags share the reset and latency of `sum_q`.
- When undefined: the ports and flag logic are absent; all other behaviour is unchanged.

## Structure

- Package `fa_4bit_pkg` holds:
  - `localparam int FA_WIDTH = 4`;
  - `typedef logic [FA_WIDTH-1:0] nibble_t`, used for `in1`, `in2`, `sum` and `sum_q`.
- Sub-module `full_adder` has ports `a, b, cin, s, cout`. It is instantiated `FA_WIDTH` times with a generate loop.
- The top level holds only the carry chain wiring, the output register and the optional flag logic.

## Test plan

- Exhaustive combinational sweep over all 512 `(in1, in2, carry_in)` combinations, checking `{carry_out, sum} === in1 + in2 + carry_in` after settle. Spot checks:
  - 0+0+0 gives 0/0.
  - 7+8+0 gives 15/0.
  - 13+15+0 gives 12/1.
  - 14+11+1 gives 10/1.
  - 15+15+1 gives 15/1.
- Carry chain: 15+0+1 gives `sum = 0`, `carry_out = 1`. Toggling `carry_in` with 15+0 flips `carry_out` with no clock.
- Register latency: drive 5+12+1 before edge N; `sum_q = 2`, `carry_out_q = 1` only after edge N, while `sum` is already 2.
- Reset: hold `rst = 1` for 2 edges with inputs 9+2+1. The registered outputs read 0 while `sum = 12`. Releasing `rst` gives `sum_q = 12` after the next edge.
- With `FA_4BIT_FLAGS_EN` defined:
  - 5+2+1 gives `ovf_q = 1`, `zero_q = 0`.
  - 15+15+1 gives `ovf_q = 0`.
  - 8+8+0 gives `zero_q = 1`, `ovf_q = 1`.
